// File: rtl/clusterv_tile_ic_arb.sv
// Round-robin Wishbone arbiter: grants one tile master at a time onto the shared
// target port and holds the grant for the master's whole cyc.
module clusterv_tile_ic_arb #(
    parameter int N_MASTERS = 4,
    parameter int ADR_W     = 32,
    parameter int DAT_W     = 32,
    parameter int TGA_W     = 1,
    parameter int TGD_W     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_MASTERS*ADR_W-1:0]     i_adr,
    input  logic [N_MASTERS*DAT_W-1:0]     i_dat_w,
    output logic [DAT_W-1:0]               i_dat_r,
    input  logic [N_MASTERS-1:0]           i_cyc,
    input  logic [N_MASTERS-1:0]           i_stb,
    input  logic [N_MASTERS-1:0]           i_we,
    input  logic [N_MASTERS*(DAT_W/8)-1:0] i_sel,
    input  logic [N_MASTERS*TGA_W-1:0]     i_tga,
    input  logic [N_MASTERS*TGD_W-1:0]     i_tgd_w,
    output logic [TGD_W-1:0]               i_tgd_r,
    output logic [N_MASTERS-1:0]           i_ack,
    output logic [N_MASTERS-1:0]           i_err,
    output logic [ADR_W-1:0]               t_adr,
    output logic [DAT_W-1:0]               t_dat_w,
    input  logic [DAT_W-1:0]               t_dat_r,
    output logic                           t_cyc,
    output logic                           t_stb,
    output logic                           t_we,
    output logic [DAT_W/8-1:0]             t_sel,
    output logic [TGA_W-1:0]               t_tga,
    output logic [TGD_W-1:0]               t_tgd_w,
    input  logic [TGD_W-1:0]               t_tgd_r,
    input  logic                           t_ack,
    input  logic                           t_err,
    output logic [N_MASTERS-1:0]           gnt
);
    localparam int SEL_W = DAT_W / 8;
    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q;
    logic [N_MASTERS-1:0] gnt_q;
    logic [IDX_W-1:0]     last_q;

    logic [N_MASTERS-1:0] req;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [N_MASTERS-1:0] win_oh;
    logic [IDX_W:0]       cand;
    logic                 gnt_cyc;

    assign req = i_cyc & i_stb;

    // Search last+1, last+2, ... so the previous winner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        win_oh    = '0;
        cand      = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_MASTERS)) begin
                cand = cand - (IDX_W+1)'(N_MASTERS);
            end
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
        if (win_found) begin
            win_oh[win_idx] = 1'b1;
        end
    end

    assign gnt_cyc = |(gnt_q & i_cyc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= BUSY;
                        gnt_q   <= win_oh;
                        last_q  <= win_idx;
                    end
                end
                BUSY: begin
                    if (!gnt_cyc) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    // AND-OR mux on the one-hot grant: an empty grant (IDLE) drives all zeros.
    always_comb begin
        t_adr   = '0;
        t_dat_w = '0;
        t_we    = 1'b0;
        t_sel   = '0;
        t_tga   = '0;
        t_tgd_w = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt_q[k]) begin
                t_adr   = t_adr   | i_adr[ADR_W*k +: ADR_W];
                t_dat_w = t_dat_w | i_dat_w[DAT_W*k +: DAT_W];
                t_we    = t_we    | i_we[k];
                t_sel   = t_sel   | i_sel[SEL_W*k +: SEL_W];
                t_tga   = t_tga   | i_tga[TGA_W*k +: TGA_W];
                t_tgd_w = t_tgd_w | i_tgd_w[TGD_W*k +: TGD_W];
            end
        end
    end

    // stb is qualified by cyc so a release cycle shows neither on the target.
    assign t_cyc   = gnt_cyc;
    assign t_stb   = |(gnt_q & i_cyc & i_stb);
    assign i_ack   = gnt_q & {N_MASTERS{t_ack}};
    assign i_err   = gnt_q & {N_MASTERS{t_err}};
    assign i_dat_r = t_dat_r;
    assign i_tgd_r = t_tgd_r;
    assign gnt     = gnt_q;
endmodule

// File: doc/clusterv_tile_ic_arb.md
Name: clusterv_tile_ic_arb

Overview:
- Round-robin Wishbone arbiter that consumes the per-tile instruction/data master buses (tile2ic_ array) from N clusterv_tile instances.
- Grants one tile at a time onto a single shared Wishbone target port, which leads to the system interconnect and the SPI flash path.
- Sits directly downstream of the tile array in user_project_wrapper.
- Holds the grant for a whole cycle (cyc) so tagged bursts and read-modify sequences stay atomic.

Parameters:
- N_MASTERS, 4, number of tile master ports (2..8)
- ADR_W, 32, address width
- DAT_W, 32, data width
- TGA_W, 1, address-tag width
- TGD_W, 1, data-tag width (both directions)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-high reset
- i_adr  in  N_MASTERS*ADR_W  master addresses, packed, master k at [ADR_W*k+:ADR_W]
- i_dat_w  in  N_MASTERS*DAT_W  master write data
- i_dat_r  out  DAT_W  read data, broadcast to all masters
- i_cyc  in  N_MASTERS  master cycle
- i_stb  in  N_MASTERS  master strobe
- i_we  in  N_MASTERS  master write enable
- i_sel  in  N_MASTERS*(DAT_W/8)  master byte selects
- i_tga  in  N_MASTERS*TGA_W  master address tags
- i_tgd_w  in  N_MASTERS*TGD_W  master write-data tags
- i_tgd_r  out  TGD_W  read-data tag, broadcast to all masters
- i_ack  out  N_MASTERS  per-master ack
- i_err  out  N_MASTERS  per-master err
- t_adr  out  ADR_W  target address
- t_dat_w  out  DAT_W  target write data
- t_dat_r  in  DAT_W  target read data
- t_cyc, t_stb, t_we  out  1 each  target controls
- t_sel  out  DAT_W/8  target byte selects
- t_tga  out  TGA_W  target address tag
- t_tgd_w  out  TGD_W  target write-data tag
- t_tgd_r  in  TGD_W  target read-data tag
- t_ack, t_err  in  1 each  target responses
- gnt  out  N_MASTERS  one-hot current grant (debug/LA)

Behaviour:
- Reset is asynchronous, active-high, on clock/reset only.
- Reset values:
  - state=IDLE, gnt=0, last=N_MASTERS-1.
  - All t_* outputs 0; i_ack=0, i_err=0.
- Request definition: req[k] = i_cyc[k] & i_stb[k].
- IDLE:
  - If any req, pick the first requester in the order last+1, last+2, … (modulo N_MASTERS).
  - Register gnt one-hot and last=winner; go to BUSY.
  - With no req, stay in IDLE with gnt=0.
- BUSY:
  - t_* = muxed signals of the granted master, combinational from the registered gnt.
  - t_cyc = i_cyc[g]; t_stb = i_stb[g].
  - i_ack[g] = t_ack and i_err[g] = t_err. All non-granted acks/errs are 0.
  - i_dat_r/i_tgd_r = t_dat_r/t_tgd_r unconditionally.
- Release: when i_cyc[g]=0 in BUSY, go to IDLE, gnt=0, t_cyc=t_stb=0 in the same cycle (combinational mux of cyc=0).
  - Re-arbitration happens in the next IDLE cycle, so there is minimum 1 idle cycle between grants.
- Latency:
  - A request seen in IDLE at edge n reaches the target at cycle n+1.
  - Ack passes combinationally from target to master (zero added cycles).
- The master may hold cyc with stb low between beats; the grant is kept.
- Fairness: after master k's cycle ends, k has lowest priority. With all N requesting continuously, grants rotate 0,1,2,3,0,…
- In IDLE all t_* outputs are driven 0; no address leakage from non-granted masters.
- A master dropping cyc mid-transfer before ack (abort) releases the bus; a late t_ack after release is dropped (no i_ack asserted).
- t_ack and t_err asserted together: both are forwarded. The master treats err as dominant.
- reset asserted mid-BUSY: immediate return to IDLE, outputs 0, last=N_MASTERS-1.
- No timeout; a hung target holds the grant indefinitely.

Test Plan:
- Single master 2 requests read adr=0x3000_0010, target acks with t_dat_r=0xDEADBEEF after 2 cycles -> t_cyc rises 1 cycle after request, gnt=4'b0100, i_ack=4'b0100 for one cycle with i_dat_r=0xDEADBEEF, gnt=0 the cycle after cyc drops.
- All 4 masters request from reset, each does one single-beat write -> grant order 0,1,2,3, each gnt separated by exactly one IDLE cycle; t_adr/t_dat_w/t_sel match the granted master.
- Master 1 does a 4-beat burst (cyc held, stb toggling) while master 3 requests -> master 3 is not granted until master 1 drops cyc; master 3 is granted next; no beat of master 1 is interleaved.
- Master 0 wins and receives ack; master 0 re-requests immediately along with master 2 -> master 2 is granted first (round-robin).
- Target returns t_err on master 3 write -> i_err=4'b1000, i_ack=0; the next request is served normally.
- Reset asserted while BUSY with master 2 mid-transfer -> t_cyc=0 and gnt=0 asynchronously; after release, master 0 requesting with master 2 -> master 0 granted (last reset to 3).
